mfp_als_spi_responder: RTL and testbench

- Synthesizable SPI responder (slave) that models the ambient-light-sensor ADC, the 8-bit ADC081S021-style part on the PmodALS.
- Serves the system's SPI master pins SPI_CS, SPI_SCK and SPI_SDO.
- Used on boards without the physical sensor, and as the bench-side peer for the SPI master.
- Samples the master's CS and SCK in the system clock domain and shifts out a 16-bit frame on SDO: leading zeros, then the data byte, then trailing zeros.

---
 rtl/mfp_als_spi_responder_pkg.sv | 17 +
 rtl/mfp_als_sync_edge.sv | 44 ++++
 rtl/mfp_als_spi_responder.sv | 166 ++++++++++++++++
 tb/tb_mfp_als_spi_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_als_spi_responder_pkg.sv
// Shared configuration for the ALS SPI responder: state encodings and default field widths.
package mfp_als_spi_responder_pkg;

   localparam int unsigned ALS_SYNC_STAGES    = 2;
   localparam int unsigned ALS_LEADING_ZEROS  = 3;
   localparam int unsigned ALS_DATA_WIDTH     = 8;
   localparam int unsigned ALS_TRAILING_ZEROS = 5;
   localparam int unsigned ALS_COUNT_WIDTH    = 16;
   localparam int unsigned ALS_BIT_CNT_WIDTH  = 5;

   typedef enum logic [1:0] {
      ALS_ST_IDLE  = 2'd0,
      ALS_ST_SHIFT = 2'd1,
      ALS_ST_DONE  = 2'd2
   } als_state_e;

endpackage

// File: rtl/mfp_als_sync_edge.sv
// Multi-flop synchronizer plus one history flop with rise/fall detection.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   pin         - asynchronous input
//   level       - synchronized level
//   rise_c      - synchronized rising edge (combinational from registers)
//   fall_c      - synchronized falling edge (combinational from registers)
//   primed      - high once every flop holds a sampled value rather than its reset value
module mfp_als_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic rise_c,
   output logic fall_c,
   output logic primed
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic [SYNC_STAGES:0]   prime_q;

   // Synchronizer chain, history flop and priming shift register
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
         hist_q  <= RESET_LEVEL;
         prime_q <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pin};
         hist_q  <= sync_q[SYNC_STAGES-1];
         prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign level  = sync_q[SYNC_STAGES-1];
   assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign fall_c = ~sync_q[SYNC_STAGES-1] & hist_q;
   assign primed = prime_q[SYNC_STAGES];

endmodule

// File: rtl/mfp_als_spi_responder.sv
// SPI responder modelling an 8-bit ambient-light-sensor ADC: on CS fall it
// shifts out {leading zeros, sample, trailing zeros} MSB first, advancing on SCK falls.
// Optional build macro MFP_ALS_RESPONDER_AUTOINC_EN: an internal counter that
// increments on each completed frame replaces sample_data as the reported value.
// Ports:
//   SI_ClkIn, SI_Reset   - system clock, synchronous active-high reset
//   SPI_CS, SPI_SCK      - master chip select (active-low) and serial clock (idle-low)
//   SPI_SDO              - serial data to master
//   sample_data          - light value captured at CS fall
//   frame_active         - frame in progress
//   frame_done           - one-cycle pulse on normal completion
//   frame_abort          - one-cycle pulse when CS rises mid-frame
//   frame_count          - completed-frame counter (wraps)
module mfp_als_spi_responder
   import mfp_als_spi_responder_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = ALS_SYNC_STAGES,
   parameter int unsigned LEADING_ZEROS  = ALS_LEADING_ZEROS,
   parameter int unsigned DATA_WIDTH     = ALS_DATA_WIDTH,
   parameter int unsigned TRAILING_ZEROS = ALS_TRAILING_ZEROS
) (
   input  logic                       SI_ClkIn,
   input  logic                       SI_Reset,
   input  logic                       SPI_CS,
   input  logic                       SPI_SCK,
   output logic                       SPI_SDO,
   input  logic [DATA_WIDTH-1:0]      sample_data,
   output logic                       frame_active,
   output logic                       frame_done,
   output logic                       frame_abort,
   output logic [ALS_COUNT_WIDTH-1:0] frame_count
);

   localparam int unsigned FRAME_BITS = LEADING_ZEROS + DATA_WIDTH + TRAILING_ZEROS;
   localparam int unsigned BCW        = ALS_BIT_CNT_WIDTH;

   logic cs_level, cs_rise, cs_fall, cs_primed;
   logic sck_fall, sck_level_unused, sck_rise_unused, sck_primed_unused;

   mfp_als_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_cs_sync (
      .clk(SI_ClkIn), .reset(SI_Reset), .pin(SPI_CS),
      .level(cs_level), .rise_c(cs_rise), .fall_c(cs_fall), .primed(cs_primed)
   );

   mfp_als_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sck_sync (
      .clk(SI_ClkIn), .reset(SI_Reset), .pin(SPI_SCK),
      .level(sck_level_unused), .rise_c(sck_rise_unused), .fall_c(sck_fall),
      .primed(sck_primed_unused)
   );

   als_state_e                 state_q, state_next;
   logic [FRAME_BITS-1:0]      shift_q, shift_next;
   logic [BCW-1:0]             bit_cnt_q, bit_cnt_next;
   logic                       armed_q, armed_next;
   logic                       sdo_next, active_next, done_next, abort_next;
   logic [ALS_COUNT_WIDTH-1:0] count_next;
   logic [DATA_WIDTH-1:0]      load_value_c;

`ifdef MFP_ALS_RESPONDER_AUTOINC_EN
   logic [DATA_WIDTH-1:0] autoinc_q, autoinc_next;
   logic                  sample_unused;
   assign sample_unused = ^sample_data;
   assign load_value_c  = autoinc_q;
`else
   assign load_value_c  = sample_data;
`endif

   // State and registered outputs
   always_ff @(posedge SI_ClkIn) begin
      if (SI_Reset) begin
         state_q      <= ALS_ST_IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         armed_q      <= 1'b0;
         SPI_SDO      <= 1'b0;
         frame_active <= 1'b0;
         frame_done   <= 1'b0;
         frame_abort  <= 1'b0;
         frame_count  <= '0;
`ifdef MFP_ALS_RESPONDER_AUTOINC_EN
         autoinc_q    <= '0;
`endif
      end else begin
         state_q      <= state_next;
         shift_q      <= shift_next;
         bit_cnt_q    <= bit_cnt_next;
         armed_q      <= armed_next;
         SPI_SDO      <= sdo_next;
         frame_active <= active_next;
         frame_done   <= done_next;
         frame_abort  <= abort_next;
         frame_count  <= count_next;
`ifdef MFP_ALS_RESPONDER_AUTOINC_EN
         autoinc_q    <= autoinc_next;
`endif
      end
   end

   // Next-state and output logic
   always_comb begin
      state_next   = state_q;
      shift_next   = shift_q;
      bit_cnt_next = bit_cnt_q;
      armed_next   = armed_q;
      sdo_next     = SPI_SDO;
      active_next  = frame_active;
      done_next    = 1'b0;
      abort_next   = 1'b0;
      count_next   = frame_count;
`ifdef MFP_ALS_RESPONDER_AUTOINC_EN
      autoinc_next = autoinc_q;
`endif

      // A CS fall only counts once CS has been seen high through a fully primed
      // synchronizer, so a CS held low across reset cannot start a frame.
      if (cs_primed && cs_level) begin
         armed_next = 1'b1;
      end

      unique case (state_q)
         ALS_ST_IDLE: begin
            sdo_next = 1'b0;
            if (cs_fall && armed_q) begin
               shift_next   = FRAME_BITS'(load_value_c) << TRAILING_ZEROS;
               bit_cnt_next = '0;
               sdo_next     = shift_next[FRAME_BITS-1];
               active_next  = 1'b1;
               state_next   = ALS_ST_SHIFT;
            end
         end
         ALS_ST_SHIFT: begin
            if (cs_rise) begin
               abort_next  = 1'b1;
               sdo_next    = 1'b0;
               active_next = 1'b0;
               state_next  = ALS_ST_IDLE;
            end else if (sck_fall) begin
               shift_next   = {shift_q[FRAME_BITS-2:0], 1'b0};
               sdo_next     = shift_q[FRAME_BITS-2];
               bit_cnt_next = bit_cnt_q + BCW'(1);
               if (bit_cnt_next == BCW'(FRAME_BITS - 1)) begin
                  state_next = ALS_ST_DONE;
               end
            end
         end
         ALS_ST_DONE: begin
            sdo_next = 1'b0;
            if (cs_rise) begin
               done_next   = 1'b1;
               count_next  = frame_count + ALS_COUNT_WIDTH'(1);
               active_next = 1'b0;
               state_next  = ALS_ST_IDLE;
`ifdef MFP_ALS_RESPONDER_AUTOINC_EN
               autoinc_next = autoinc_q + DATA_WIDTH'(1);
`endif
            end
         end
         default: begin
            sdo_next    = 1'b0;
            active_next = 1'b0;
            state_next  = ALS_ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mfp_als_spi_responder.sv
// Directed bench for mfp_als_spi_responder: acts as SPI master with 8-clock SCK phases.
module tb_mfp_als_spi_responder;

   logic        clk;
   logic        rst;
   logic        cs;
   logic        sck;
   logic        sdo;
   logic [7:0]  sample_data;
   logic        frame_active;
   logic        frame_done;
   logic        frame_abort;
   logic [15:0] frame_count;

   int n_checks = 0;
   int n_pass   = 0;
   int done_seen  = 0;
   int abort_seen = 0;
   logic [15:0] exp_count = 16'd0;

   mfp_als_spi_responder dut (
      .SI_ClkIn     (clk),
      .SI_Reset     (rst),
      .SPI_CS       (cs),
      .SPI_SCK      (sck),
      .SPI_SDO      (sdo),
      .sample_data  (sample_data),
      .frame_active (frame_active),
      .frame_done   (frame_done),
      .frame_abort  (frame_abort),
      .frame_count  (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1)  done_seen++;
      if (frame_abort === 1'b1) abort_seen++;
   end

   // CS low, then n_sck SCK cycles sampling SDO just before each rise; CS left low.
   task automatic run_frame(input int n_sck, input int chg_at, input logic [7:0] chg_val,
                            output logic [31:0] rx, output logic active_mid);
      rx = '0;
      active_mid = 1'b0;
      @(negedge clk) cs = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < n_sck; i++) begin
         if (i == chg_at) sample_data = chg_val;
         rx = {rx[30:0], sdo};
         if (i == 1) active_mid = frame_active;
         sck = 1'b1;
         repeat (8) @(negedge clk);
         sck = 1'b0;
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic end_frame();
      cs = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; cs = 1'b1; sck = 1'b0; sample_data = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({sdo, frame_active, frame_done, frame_abort} !== 4'b0000)
         $display("FAIL reset_flags: got %b expected 0000", {sdo, frame_active, frame_done, frame_abort});
      else n_pass++;
      n_checks++;
      if (frame_count !== 16'h0000) $display("FAIL reset_count: got %h expected 0000", frame_count);
      else n_pass++;
      rst = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   // Normal frame with given sample, checking word, done pulse and count
   task automatic test_frame(input string name, input logic [7:0] val, input logic [15:0] exp_word);
      logic [31:0] rx;
      logic act;
      int d0;
      sample_data = val;
      d0 = done_seen;
      run_frame(16, -1, 8'h00, rx, act);
      n_checks++;
      if (act !== 1'b1) $display("FAIL %s_active: got %b expected 1", name, act);
      else n_pass++;
      end_frame();
      exp_count = exp_count + 16'd1;
      n_checks++;
      if (rx[15:0] !== exp_word) $display("FAIL %s_word: got %h expected %h", name, rx[15:0], exp_word);
      else n_pass++;
      n_checks++;
      if (done_seen - d0 !== 1) $display("FAIL %s_done: got %0d pulses expected 1", name, done_seen - d0);
      else n_pass++;
      n_checks++;
      if (frame_count !== exp_count) $display("FAIL %s_count: got %h expected %h", name, frame_count, exp_count);
      else n_pass++;
   endtask

   task automatic test_midframe_change();
      logic [31:0] rx;
      logic act;
      sample_data = 8'h3C;
      run_frame(16, 5, 8'hC3, rx, act);
      end_frame();
      exp_count = exp_count + 16'd1;
      n_checks++;
      if (rx[15:0] !== 16'h0780) $display("FAIL midchange_word: got %h expected 0780", rx[15:0]);
      else n_pass++;
   endtask

   task automatic test_abort();
      logic [31:0] rx;
      logic act;
      int d0, a0;
      sample_data = 8'hA5;
      d0 = done_seen; a0 = abort_seen;
      run_frame(6, -1, 8'h00, rx, act);
      end_frame();
      n_checks++;
      if (abort_seen - a0 !== 1) $display("FAIL abort_pulse: got %0d expected 1", abort_seen - a0);
      else n_pass++;
      n_checks++;
      if (done_seen - d0 !== 0) $display("FAIL abort_nodone: got %0d expected 0", done_seen - d0);
      else n_pass++;
      n_checks++;
      if (frame_count !== exp_count) $display("FAIL abort_count: got %h expected %h", frame_count, exp_count);
      else n_pass++;
      n_checks++;
      if ({sdo, frame_active} !== 2'b00) $display("FAIL abort_idle: got %b expected 00", {sdo, frame_active});
      else n_pass++;
      test_frame("after_abort", 8'h5A, 16'h0B40);
   endtask

   task automatic test_reset_midframe();
      logic [31:0] rx;
      logic act;
      logic [3:0] post;
      sample_data = 8'hFF;
      run_frame(9, -1, 8'h00, rx, act);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_count = 16'd0;
      n_checks++;
      if ({sdo, frame_active} !== 2'b00) $display("FAIL rstmid_idle: got %b expected 00", {sdo, frame_active});
      else n_pass++;
      n_checks++;
      if (frame_count !== 16'h0000) $display("FAIL rstmid_count: got %h expected 0000", frame_count);
      else n_pass++;
      // CS stays low: SCK activity must not start a frame
      post = '0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         post = {post[2:0], sdo};
         sck = 1'b1;
         repeat (8) @(negedge clk);
         sck = 1'b0;
         repeat (8) @(negedge clk);
      end
      n_checks++;
      if ({post, frame_active} !== 5'b00000)
         $display("FAIL rstmid_nostart: got %b expected 00000", {post, frame_active});
      else n_pass++;
      end_frame();
      test_frame("after_reset", 8'h81, 16'h1020);
   endtask

   task automatic test_overrun();
      logic [31:0] rx;
      logic act;
      int d0;
      sample_data = 8'h96;
      d0 = done_seen;
      run_frame(20, -1, 8'h00, rx, act);
      end_frame();
      exp_count = exp_count + 16'd1;
      n_checks++;
      if (rx[19:4] !== 16'h12C0) $display("FAIL overrun_word: got %h expected 12c0", rx[19:4]);
      else n_pass++;
      n_checks++;
      if (rx[3:0] !== 4'h0) $display("FAIL overrun_tail: got %h expected 0", rx[3:0]);
      else n_pass++;
      n_checks++;
      if (done_seen - d0 !== 1 || frame_count !== exp_count)
         $display("FAIL overrun_done: got %0d pulses count %h expected 1 pulse count %h",
                  done_seen - d0, frame_count, exp_count);
      else n_pass++;
   endtask

   task automatic test_autoinc();
      logic [31:0] rx;
      logic act;
      logic [15:0] exp_word;
      for (int k = 0; k < 3; k++) begin
         sample_data = 8'hFF;
         run_frame(16, -1, 8'h00, rx, act);
         end_frame();
         exp_word = 16'(k) << 5;
         n_checks++;
         if (rx[15:0] !== exp_word) $display("FAIL autoinc_word%0d: got %h expected %h", k, rx[15:0], exp_word);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
`ifdef MFP_ALS_RESPONDER_AUTOINC_EN
      test_autoinc();
`else
      test_frame("readout", 8'hA5, 16'h14A0);
      test_frame("fullscale", 8'hFF, 16'h1FE0);
      test_frame("zero", 8'h00, 16'h0000);
      test_midframe_change();
      test_abort();
      test_reset_midframe();
      test_overrun();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
